matmul_stream_engine: RTL and testbench

Parametrised N×N matrix-multiply engine for the UART matrix datapath. It accepts a byte stream carrying a size byte, then matrix A, then matrix B, all row-major. It computes C = A·B with a single time-shared multiply-accumulate unit and streams C out byte-serially with valid/ready backpressure toward the UART transmitter. It supersedes the fixed 3×3 unsigned path: runtime size 1..MAX_N, optional signed arithmetic, abort, and size-error reporting.

---
 rtl/matmul_stream_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_matmul_stream_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_engine.sv
// N x N matrix multiply over a byte stream: size, A, B in; C out least-significant byte first.
// One pipelined multiply-accumulate unit is time-shared across all n^3 products.
module matmul_stream_engine #(
    parameter int unsigned MAX_N  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic       bclk,
    input  logic       rst,
    input  logic       abort_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       busy_o,
    output logic       err_size_o,
    output logic       done_o
);

    localparam int unsigned ACC_W     = 17 + $clog2(MAX_N);
    localparam int unsigned OUT_BYTES = (ACC_W + 7) / 8;
    localparam int unsigned PAD       = 8 * OUT_BYTES - ACC_W;
    localparam int unsigned NW        = $clog2(MAX_N + 1);
    localparam int unsigned IW        = $clog2(MAX_N);
    localparam int unsigned AW        = $clog2(MAX_N * MAX_N);
    localparam int unsigned CW        = $clog2(MAX_N * MAX_N * MAX_N + 3);
    localparam int unsigned BW        = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StCompute, StSend} state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [IW-1:0]   row_q, row_d, col_q, col_d, k_q, k_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            done_q, done_d, err_q, err_d;

    logic             p_vld_q, p_first_q, p_last_q;
    logic [AW-1:0]    p_addr_q;
    logic [ACC_W-1:0] prod_q, acc_q, acc_sum;

    logic [7:0]       a_mem [MAX_N*MAX_N];
    logic [7:0]       b_mem [MAX_N*MAX_N];
    logic [ACC_W-1:0] c_mem [MAX_N*MAX_N];

    logic [IW-1:0]      last_idx;
    logic               row_last, col_last, k_last, byte_last;
    logic [CW-1:0]      n_cube;
    logic               issue, aborting, load_we;
    logic [7:0]         a_rd, b_rd;
    logic signed [8:0]  a_ext, b_ext;
    logic signed [17:0] prod_w;

    function automatic logic [AW-1:0] addr(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return AW'(int'(r) * MAX_N + int'(c));
    endfunction

    // Byte b of the result after widening to the transmitted width.
    function automatic logic [7:0] pick(input logic [ACC_W-1:0] v, input logic [BW-1:0] b);
        logic [8*OUT_BYTES-1:0] ext;
        ext = {{PAD{SIGNED & v[ACC_W-1]}}, v};
        return ext[8*b +: 8];
    endfunction

    assign last_idx  = IW'(n_q - NW'(1));
    assign row_last  = (row_q == last_idx);
    assign col_last  = (col_q == last_idx);
    assign k_last    = (k_q == last_idx);
    assign byte_last = (byte_q == BW'(OUT_BYTES - 1));
    assign n_cube    = CW'(n_q) * CW'(n_q) * CW'(n_q);
    assign aborting  = abort_i && (state_q != StIdle);
    assign load_we   = in_valid_i && !abort_i && (state_q == StLoadA || state_q == StLoadB);

    assign a_rd    = a_mem[addr(row_q, k_q)];
    assign b_rd    = b_mem[addr(k_q, col_q)];
    assign a_ext   = $signed({SIGNED & a_rd[7], a_rd});
    assign b_ext   = $signed({SIGNED & b_rd[7], b_rd});
    assign prod_w  = a_ext * b_ext;
    assign acc_sum = (p_first_q ? '0 : acc_q) + prod_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        row_d       = row_q;
        col_d       = col_q;
        k_d         = k_q;
        byte_d      = byte_q;
        cyc_d       = cyc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    if (in_data_i != 8'd0 && in_data_i <= 8'(MAX_N)) begin
                        n_d     = NW'(in_data_i);
                        row_d   = '0;
                        col_d   = '0;
                        state_d = StLoadA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoadA, StLoadB: begin
                if (in_valid_i) begin
                    col_d = col_q + IW'(1);
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + IW'(1);
                        if (row_last) begin
                            row_d   = '0;
                            k_d     = '0;
                            cyc_d   = '0;
                            state_d = (state_q == StLoadA) ? StLoadB : StCompute;
                        end
                    end
                end
            end
            StCompute: begin
                cyc_d = cyc_q + CW'(1);
                if (cyc_q < n_cube) begin
                    issue = 1'b1;
                    k_d   = k_q + IW'(1);
                    if (k_last) begin
                        k_d   = '0;
                        col_d = col_q + IW'(1);
                        if (col_last) begin
                            col_d = '0;
                            row_d = row_q + IW'(1);
                        end
                    end
                end
                // Two extra cycles let the last product drain through the accumulator.
                if (cyc_q == n_cube + CW'(1)) begin
                    state_d     = StSend;
                    row_d       = '0;
                    col_d       = '0;
                    byte_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = pick(c_mem[0], '0);
                end
            end
            StSend: begin
                if (out_valid_q && out_ready_i) begin
                    if (byte_last && row_last && col_last) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        byte_d      = '0;
                        row_d       = '0;
                        col_d       = '0;
                    end else begin
                        byte_d = byte_q + BW'(1);
                        if (byte_last) begin
                            byte_d = '0;
                            col_d  = col_q + IW'(1);
                            if (col_last) begin
                                col_d = '0;
                                row_d = row_q + IW'(1);
                            end
                        end
                        out_data_d = pick(c_mem[addr(row_d, col_d)], byte_d);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (aborting) begin
            state_d     = StIdle;
            row_d       = '0;
            col_d       = '0;
            k_d         = '0;
            byte_d      = '0;
            cyc_d       = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            issue       = 1'b0;
        end
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
            byte_q      <= '0;
            cyc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            p_vld_q     <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_addr_q    <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            k_q         <= k_d;
            byte_q      <= byte_d;
            cyc_q       <= cyc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            p_vld_q     <= issue;
            p_first_q   <= (k_q == '0);
            p_last_q    <= k_last;
            p_addr_q    <= addr(row_q, col_q);
            prod_q      <= ACC_W'(prod_w);
            if (p_vld_q) begin
                acc_q <= acc_sum;
            end
        end
    end

    always_ff @(posedge bclk) begin
        if (load_we && state_q == StLoadA) begin
            a_mem[addr(row_q, col_q)] <= in_data_i;
        end
        if (load_we && state_q == StLoadB) begin
            b_mem[addr(row_q, col_q)] <= in_data_i;
        end
        if (p_vld_q && p_last_q) begin
            c_mem[p_addr_q] <= acc_sum;
        end
    end

    assign in_ready_o  = (state_q == StIdle) || (state_q == StLoadA) || (state_q == StLoadB);
    assign busy_o      = (state_q != StIdle);
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign err_size_o  = err_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Bench for matmul_stream_engine: unsigned and signed instances driven in lockstep, results
// compared against an integer matrix-product model.
module tb_matmul_stream_engine;

    localparam int MAX_N = 4;
    localparam int OB    = 3;

    logic       bclk      = 1'b0;
    logic       rst       = 1'b1;
    logic       abort_in  = 1'b0;
    logic [7:0] in_data   = 8'd0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_u, out_valid_u, busy_u, err_u, done_u;
    logic       in_ready_s, out_valid_s, busy_s, err_s, done_s;
    logic [7:0] out_data_u, out_data_s;

    matmul_stream_engine #(.MAX_N(MAX_N), .SIGNED(1'b0)) u_dut_u (
        .bclk(bclk), .rst(rst), .abort_i(abort_in),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_u),
        .out_data_o(out_data_u), .out_valid_o(out_valid_u), .out_ready_i(out_ready),
        .busy_o(busy_u), .err_size_o(err_u), .done_o(done_u)
    );

    matmul_stream_engine #(.MAX_N(MAX_N), .SIGNED(1'b1)) u_dut_s (
        .bclk(bclk), .rst(rst), .abort_i(abort_in),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
        .out_data_o(out_data_s), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
        .busy_o(busy_s), .err_size_o(err_s), .done_o(done_s)
    );

    always #5 bclk = ~bclk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] ma [MAX_N][MAX_N];
    logic [7:0] mb [MAX_N][MAX_N];
    logic [7:0] exp_u[$], exp_s[$], got_u[$], got_s[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    // C = A*B with plain integers, then each element as OB little-endian bytes.
    task automatic build_model(input int n);
        exp_u.delete();
        exp_s.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                int su, ss;
                su = 0;
                ss = 0;
                for (int k = 0; k < n; k++) begin
                    su += int'(ma[i][k]) * int'(mb[k][j]);
                    ss += int'($signed(ma[i][k])) * int'($signed(mb[k][j]));
                end
                for (int b = 0; b < OB; b++) begin
                    exp_u.push_back(8'(su >>> (8 * b)));
                    exp_s.push_back(8'(ss >>> (8 * b)));
                end
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        check_eq("in_ready_load", in_ready_u, 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // mode: 0 = sink always ready, 1 = ready one cycle in three, 2 = random ready.
    task automatic run_job(input int n, input int mode, input int stop_after, input bit use_rst,
                           input bit gaps);
        int         lat, cyc, nb;
        bit         vprev, rdy, last;
        logic [7:0] dpu, dps;
        build_model(n);
        got_u.delete();
        got_s.delete();
        nb = n * n * OB;
        check_eq("busy_idle", busy_u, 0);
        push_byte(8'(n), gaps);
        check_eq("no_err_size", err_u, 0);
        check_eq("busy_load", busy_u, 1);
        for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) push_byte(ma[i][j], gaps);
        for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) push_byte(mb[i][j], gaps);
        check_eq("in_ready_compute", in_ready_u, 0);
        check_eq("busy_compute", busy_s, 1);
        lat      = 0;
        in_valid = 1'b1;
        while (!out_valid_u && lat < 1000) begin
            in_data = 8'($urandom);
            tick();
            lat++;
        end
        check_eq("first_valid_latency", lat, n * n * n + 2);
        check_eq("valid_lockstep", out_valid_s, out_valid_u);
        if (!out_valid_u) begin
            in_valid = 1'b0;
            return;
        end
        cyc = 0;
        while (got_u.size() < nb && cyc < 5000) begin
            if (stop_after >= 0 && got_u.size() == stop_after) begin
                if (use_rst) begin
                    rst = 1'b1;
                    #2;
                    check_eq("rst_out_valid", out_valid_u, 0);
                    check_eq("rst_out_data", out_data_u, 0);
                    check_eq("rst_busy", busy_u, 0);
                    check_eq("rst_in_ready", in_ready_u, 1);
                    check_eq("rst_done", done_u, 0);
                    in_valid = 1'b0;
                    tick();
                    rst = 1'b0;
                end else begin
                    abort_in  = 1'b1;
                    out_ready = 1'b1;
                    tick();
                    abort_in = 1'b0;
                    in_valid = 1'b0;
                    check_eq("abort_out_valid", out_valid_u, 0);
                    check_eq("abort_busy", busy_u, 0);
                    check_eq("abort_in_ready", in_ready_u, 1);
                    check_eq("abort_done", done_u, 0);
                    tick();
                    check_eq("abort_stays_idle", out_valid_u, 0);
                end
                out_ready = 1'b0;
                return;
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 3 == 2);
            else rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            vprev     = out_valid_u;
            dpu       = out_data_u;
            dps       = out_data_s;
            last      = vprev && rdy && (got_u.size() == nb - 1);
            check_eq("valid_held", vprev, 1);
            in_data = 8'($urandom);
            tick();
            cyc++;
            if (last) in_valid = 1'b0;
            if (vprev && rdy) begin
                got_u.push_back(dpu);
                got_s.push_back(dps);
                check_eq("done_pulse", done_u, last);
                check_eq("done_pulse_s", done_s, last);
                check_eq("busy_after_xfer", busy_u, !last);
            end else if (vprev) begin
                check_eq("stall_valid", out_valid_u, 1);
                check_eq("stall_data_u", out_data_u, dpu);
                check_eq("stall_data_s", out_data_s, dps);
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("byte_count", got_u.size(), nb);
        for (int i = 0; i < got_u.size() && i < nb; i++) begin
            check_eq($sformatf("c_u[%0d]", i), got_u[i], exp_u[i]);
            check_eq($sformatf("c_s[%0d]", i), got_s[i], exp_s[i]);
        end
        if (got_u.size() == nb) begin
            check_eq("done_in_ready", in_ready_u, 1);
            check_eq("done_out_valid", out_valid_u, 0);
            tick();
            check_eq("done_one_cycle", done_u, 0);
        end
    endtask

    task automatic size_err(input logic [7:0] s);
        check_eq("in_ready_idle", in_ready_u, 1);
        in_valid = 1'b1;
        in_data  = s;
        tick();
        in_valid = 1'b0;
        check_eq("err_pulse_u", err_u, 1);
        check_eq("err_pulse_s", err_s, 1);
        check_eq("err_busy", busy_u, 0);
        check_eq("err_in_ready", in_ready_u, 1);
        tick();
        check_eq("err_one_cycle", err_u, 0);
        check_eq("err_busy_after", busy_u, 0);
    endtask

    task automatic set_seq(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                ma[i][j] = 8'(i * n + j + 1);
                mb[i][j] = 8'(i * n + j + 5);
            end
        end
    endtask

    task automatic set_one(input logic [7:0] a, input logic [7:0] b);
        ma[0][0] = a;
        mb[0][0] = b;
    endtask

    initial begin
        repeat (2) @(posedge bclk);
        #1;
        check_eq("reset_in_ready", in_ready_u, 1);
        check_eq("reset_out_valid", out_valid_u, 0);
        check_eq("reset_out_data", out_data_u, 0);
        check_eq("reset_busy", busy_u, 0);
        check_eq("reset_err", err_u, 0);
        check_eq("reset_done", done_u, 0);
        rst = 1'b0;
        tick();

        set_seq(2);
        run_job(2, 0, -1, 1'b0, 1'b0);
        check_eq("n2_c00", got_u[0], 8'h13);
        check_eq("n2_c01", got_u[3], 8'h16);
        check_eq("n2_c10", got_u[6], 8'h2B);
        check_eq("n2_c11", got_u[9], 8'h32);

        for (int i = 0; i < MAX_N; i++) begin
            for (int j = 0; j < MAX_N; j++) begin
                ma[i][j] = 8'hFF;
                mb[i][j] = 8'hFF;
            end
        end
        run_job(4, 0, -1, 1'b0, 1'b1);
        check_eq("ff_b0", got_u[0], 8'h04);
        check_eq("ff_b1", got_u[1], 8'hF8);
        check_eq("ff_b2", got_u[2], 8'h03);
        check_eq("ff_signed_b1", got_s[1], 8'h00);

        set_one(8'h80, 8'h7F);
        run_job(1, 2, -1, 1'b0, 1'b0);
        check_eq("s80_b1", got_s[1], 8'hC0);
        check_eq("s80_b2", got_s[2], 8'hFF);
        check_eq("u80_b1", got_u[1], 8'h3F);
        check_eq("u80_b2", got_u[2], 8'h00);

        size_err(8'h00);
        size_err(8'h05);
        size_err(8'h84);
        size_err(8'hFF);
        set_one(8'd3, 8'd5);
        run_job(1, 0, -1, 1'b0, 1'b0);
        check_eq("n1_b0", got_u[0], 8'h0F);

        set_seq(2);
        run_job(2, 1, -1, 1'b0, 1'b0);

        run_job(2, 0, 4, 1'b0, 1'b0);
        set_one(8'd3, 8'd5);
        run_job(1, 0, -1, 1'b0, 1'b0);

        set_seq(3);
        run_job(3, 2, 5, 1'b1, 1'b1);
        set_one(8'd3, 8'd5);
        run_job(1, 2, -1, 1'b0, 1'b0);

        repeat (25) begin
            int n;
            n = int'($urandom_range(1, MAX_N));
            for (int i = 0; i < MAX_N; i++) begin
                for (int j = 0; j < MAX_N; j++) begin
                    ma[i][j] = 8'($urandom);
                    mb[i][j] = 8'($urandom);
                end
            end
            run_job(n, int'($urandom_range(0, 2)), -1, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
